// File: rtl/thiele_pyexec_responder.sv
// thiele_pyexec_responder: PYEXEC port responder bridging the CPU to a tagged host mailbox with digest checking
module thiele_pyexec_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [31:0] DIGEST_ADDR    = 32'h0000_0005,
  parameter logic [31:0] TIMEOUT_RC     = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        py_req,
  input  logic [31:0] py_code_addr,
  output logic        py_ack,
  output logic [31:0] py_result,
  output logic        host_req_valid,
  input  logic        host_req_ready,
  output logic [31:0] host_req_addr,
  output logic [7:0]  host_req_tag,
  input  logic        host_rsp_valid,
  input  logic [7:0]  host_rsp_tag,
  input  logic [31:0] host_rsp_rc,
  output logic        busy,
  output logic        digest_valid,
  output logic [31:0] digest_value,
  output logic [4:0]  err_flags,
  output logic [15:0] call_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        py_ack_q, py_ack_d;
  logic [31:0] py_result_q, py_result_d;
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  tag_q, tag_d;
  logic        busy_q, busy_d;
  logic        dv_q, dv_d;
  logic [31:0] dig_q, dig_d;
  logic [4:0]  err_q, err_d;
  logic [15:0] count_q, count_d;
  logic        rsp_hit;
  assign rsp_hit        = host_rsp_valid && host_rsp_tag == tag_q;
  assign py_ack         = py_ack_q;
  assign py_result      = py_result_q;
  assign host_req_valid = valid_q;
  assign host_req_addr  = addr_q;
  assign host_req_tag   = tag_q;
  assign busy           = busy_q;
  assign digest_valid   = dv_q;
  assign digest_value   = dig_q;
  assign err_flags      = err_q;
  assign call_count     = count_q;
  // Next-state: request issue, response/timeout completion, digest and error bookkeeping
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    py_ack_d    = 1'b0;
    py_result_d = py_result_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    tag_d       = tag_q;
    dv_d        = dv_q;
    dig_d       = dig_q;
    err_d       = err_q;
    count_d     = count_q;
    unique case (state_q)
      IDLE: if (py_req && !py_ack_q) begin
        addr_d  = py_code_addr;
        tag_d   = tag_q + 8'd1;
        valid_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: if (host_req_ready) begin
        valid_d = 1'b0;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (rsp_hit) begin
          py_result_d = host_rsp_rc;
          py_ack_d    = 1'b1;
          count_d     = count_q + 16'd1;
          state_d     = ACK;
          if (addr_q == DIGEST_ADDR) begin
            if (host_rsp_rc == '0) err_d[1] = 1'b1;
            else if (!dv_q) begin
              dv_d  = 1'b1;
              dig_d = host_rsp_rc;
            end else if (host_rsp_rc != dig_q) err_d[2] = 1'b1;
          end else if (host_rsp_rc != '0) err_d[3] = 1'b1;
        end else if (cnt_q == TIMEOUT_CYCLES) begin
          py_result_d = TIMEOUT_RC;
          py_ack_d    = 1'b1;
          count_d     = count_q + 16'd1;
          err_d[0]    = 1'b1;
          state_d     = ACK;
        end else cnt_d = cnt_q + 32'd1;
        if (host_rsp_valid && !rsp_hit) err_d[4] = 1'b1;
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (host_rsp_valid && state_q != WAIT) err_d[4] = 1'b1;
    busy_d = state_d != IDLE;
  end
  // State and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      py_ack_q    <= 1'b0;
      py_result_q <= '0;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      tag_q       <= '0;
      busy_q      <= 1'b0;
      dv_q        <= 1'b0;
      dig_q       <= '0;
      err_q       <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      py_ack_q    <= py_ack_d;
      py_result_q <= py_result_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      tag_q       <= tag_d;
      busy_q      <= busy_d;
      dv_q        <= dv_d;
      dig_q       <= dig_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end
endmodule
